// File: rtl/debounce_pkg.sv
// Shared constants and sizing helper for the pad debounce stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package debounce_pkg;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 10;

  // Width of the per-channel stability counter; one spare bit above the
  // minimum keeps the counter comfortably wide for STABLE_TICKS = 1.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks) + 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level and edge strobes.
// Latency: 2 cycles sync plus STABLE_TICKS ticks of stability before dout follows din.
// Backpressure: none; rise/fall are single-cycle strobes that are not held for a consumer.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int                CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]     LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          dout_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  // Next-state: idle (s == dout) keeps the count cleared; pending counts ticks
  // and accepts the new level on the STABLE_TICKS-th one. ena low freezes all.
  always_comb begin
    cnt_nxt  = cnt;
    dout_nxt = dout;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (ena) begin
      if (s == dout) begin
        cnt_nxt = '0;
      end else if (tick) begin
        if (cnt == LAST) begin
          dout_nxt = s;
          cnt_nxt  = '0;
          rise_nxt = s;
          fall_nxt = ~s;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  // State registers; the synchroniser samples regardless of ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s    <= s1;
      cnt  <= cnt_nxt;
      dout <= dout_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/din_debounce.sv
// Pad input conditioning: shared tick prescaler feeding N independent debounce channels.
// Latency: 2 + (cycles to first tick) + (STABLE_TICKS-1)*TICK_DIV cycles from din edge to dout.
// Backpressure: none; outputs are free-running levels and one-cycle strobes.
module din_debounce
  import debounce_pkg::*;
#(
  parameter int N            = 1,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  // With TICK_DIV = 1 the counter sits at 0 == PRE_LAST, so tick follows ena.
  assign tick = ena && (pre == PRE_LAST);

  // Prescaler: wraps 0..TICK_DIV-1, holds while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (ena) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .tick (tick),
      .din  (din[g]),
      .dout (dout[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

endmodule

// File: tb/tb_din_debounce.sv
// Bench for din_debounce: directed scenarios plus random stimulus against a tick-counting model.
// Latency: n/a.
// Backpressure: n/a.
module tb_din_debounce;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [0:0]   din_d;
  logic [0:0]   dout_d;
  logic [0:0]   rise_d;
  logic [0:0]   fall_d;

  always #5 clk = ~clk;

  din_debounce #(.N(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
    .dout(dout), .rise(rise), .fall(fall)
  );

  din_debounce #(.N(1), .TICK_DIV(1), .STABLE_TICKS(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din_d),
    .dout(dout_d), .rise(rise_d), .fall(fall_d)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: s is din two edges late; a tick is every TD-th enabled
  // edge since reset; a channel accepts after ST ticks seen while s != dout.
  logic [N-1:0] m_s1   = '0;
  logic [N-1:0] m_s    = '0;
  logic [N-1:0] m_dout = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  int           m_ecnt = 0;
  int           m_ticks [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across the coming clock edge using current inputs.
  task automatic model_edge();
    bit tk;
    if (!rst_n) begin
      m_s1 = '0; m_s = '0; m_dout = '0; m_rise = '0; m_fall = '0; m_ecnt = 0;
      for (int c = 0; c < N; c++) m_ticks[c] = 0;
      return;
    end
    tk = ena && ((m_ecnt % TD) == TD - 1);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
      if (ena) begin
        if (m_s[c] == m_dout[c]) begin
          m_ticks[c] = 0;
        end else if (tk) begin
          m_ticks[c]++;
          if (m_ticks[c] == ST) begin
            m_dout[c]  = m_s[c];
            m_rise[c]  = m_s[c];
            m_fall[c]  = ~m_s[c];
            m_ticks[c] = 0;
          end
        end
      end
    end
    m_s  = m_s1;
    m_s1 = din;
    if (ena) m_ecnt++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("rise_fall_excl", 32'(rise & fall), 32'd0);
  endtask

  task automatic wait_change(input int ch, input logic target, input int limit,
                             output bit seen, output int cyc, output int rp, output int fp);
    seen = 1'b0; cyc = 0; rp = 0; fp = 0;
    for (int i = 1; i <= limit && !seen; i++) begin
      step();
      rp += int'(rise[ch]);
      fp += int'(fall[ch]);
      if (dout[ch] === target) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
  endtask

  initial begin
    bit seen;
    int cyc;
    int rp;
    int fp;
    int strobes;
    bit found;
    logic r_at;

    for (int c = 0; c < N; c++) m_ticks[c] = 0;

    // Reset held with inputs high.
    rst_n = 1'b0; ena = 1'b1; din = 2'b11; din_d = 1'b0;
    repeat (3) step();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rise", 32'(rise), 32'd0);
    chk("rst_fall", 32'(fall), 32'd0);

    // Release: both channels rise within the latency window.
    rst_n = 1'b1;
    wait_change(0, 1'b1, 30, seen, cyc, rp, fp);
    chk("rst_accept_seen", 32'(seen), 32'd1);
    chk("rst_latency_in_11_14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
    chk("rst_rise_pulses", 32'(rp), 32'd1);
    step();
    chk("rst_rise_cleared", 32'(rise[0]), 32'd0);
    chk("rst_dout1_high", 32'(dout[1]), 32'd1);

    // Glitch shorter than acceptance on channel 0.
    strobes = 0;
    din[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin step(); strobes += int'(rise[0]) + int'(fall[0]); end
    din[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); strobes += int'(rise[0]) + int'(fall[0]); end
    chk("glitch_dout_held", 32'(dout[0]), 32'd1);
    chk("glitch_no_strobes", 32'(strobes), 32'd0);

    // Clean falling edge on channel 1.
    din[1] = 1'b0;
    wait_change(1, 1'b0, 30, seen, cyc, rp, fp);
    chk("fall_seen", 32'(seen), 32'd1);
    chk("fall_latency_in_11_14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
    chk("fall_pulses", 32'(fp), 32'd1);
    chk("fall_no_rise", 32'(rp), 32'd0);
    chk("fall_ch0_unaffected", 32'(dout[0]), 32'd1);
    step();
    chk("fall_strobe_cleared", 32'(fall[1]), 32'd0);

    // Enable freeze during a pending change on channel 0.
    strobes = 0;
    din[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); strobes += int'(rise[0]) + int'(fall[0]); end
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); strobes += int'(rise[0]) + int'(fall[0]); end
    chk("freeze_dout_held", 32'(dout[0]), 32'd1);
    chk("freeze_no_strobes", 32'(strobes), 32'd0);
    ena = 1'b1;
    wait_change(0, 1'b0, 30, seen, cyc, rp, fp);
    chk("freeze_accept_seen", 32'(seen), 32'd1);
    chk("freeze_enabled_latency_in_11_14", 32'(6 + cyc >= 11 && 6 + cyc <= 14), 32'd1);
    chk("freeze_fall_pulses", 32'(fp), 32'd1);

    // Reset one edge before the expected acceptance.
    din[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (m_ticks[0] == ST - 1 && (m_ecnt % TD) == TD - 1) found = 1'b1;
    end
    chk("midrst_point_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_dout_low", 32'(dout[0]), 32'd0);
    chk("midrst_no_rise", 32'(rise[0]), 32'd0);
    rst_n = 1'b1;
    wait_change(0, 1'b1, 30, seen, cyc, rp, fp);
    chk("midrst_accept_seen", 32'(seen), 32'd1);
    chk("midrst_restart_latency", 32'(cyc >= 11 && cyc <= 14), 32'd1);
    chk("midrst_rise_pulses", 32'(rp), 32'd1);

    // Random levels, hold times and enable gaps.
    for (int seg = 0; seg < 150; seg++) begin
      din = 2'($urandom_range(0, 3));
      ena = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 24)) step();
    end

    // Degenerate instance: TICK_DIV = 1, STABLE_TICKS = 1.
    ena = 1'b1;
    repeat (5) step();
    chk("degen_idle_low", 32'(dout_d), 32'd0);
    din_d = 1'b1;
    seen = 1'b0; cyc = 0; r_at = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      step();
      if (dout_d[0] === 1'b1) begin
        seen = 1'b1; cyc = i; r_at = rise_d[0];
      end
    end
    chk("degen_seen", 32'(seen), 32'd1);
    chk("degen_latency_3", 32'(cyc), 32'd3);
    chk("degen_rise_at_accept", 32'(r_at), 32'd1);
    chk("degen_no_fall", 32'(fall_d), 32'd0);
    step();
    chk("degen_rise_cleared", 32'(rise_d), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
